uart_slave: RTL and testbench



---
 rtl/uart_slave.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_slave.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_slave.sv
// uart_slave: memory-mapped 8N1 UART on a RIB slave port.
//
// Ports:
//   clk     system clock
//   rst     asynchronous, active-high reset
//   addr_i  byte address; only [7:0] is decoded
//   data_i  write data
//   data_o  read data, combinational from addr_i and register state
//   we_i    write enable; every rising clk edge with we_i=1 is one write
//   rx_i    serial input (asynchronous to clk)
//   tx_o    serial output, registered, idle high
//   irq_o   registered level interrupt: irq_en & rx_valid
//
// Bus semantics: there is no valid/ready handshake. A write completes on the
// rising edge where we_i=1, and the slave never stalls. A read is purely
// combinational and has no side effects.
//
// Register map (addr_i[7:0]):
//   0x00 CTRL   {irq_en, rx_en, tx_en}
//   0x04 STATUS {frame_err, rx_overrun, rx_valid, tx_busy}; writing 0 clears a flag
//   0x08 BAUD   clocks per bit, clamped to MIN_DIV on write
//   0x0C TXDATA write starts a frame when tx_en=1 and the transmitter is free
//   0x10 RXDATA last accepted byte
module uart_slave #(
    parameter int DEFAULT_DIV = 434,
    parameter int MIN_DIV     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        we_i,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        irq_o
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [15:0] DEFAULT_W = 16'(DEFAULT_DIV);
    localparam logic [15:0] MIN_W     = 16'(MIN_DIV);

    logic [2:0]  ctrl;
    logic [15:0] baud;
    logic [7:0]  txdata, rxdata;
    logic        rx_valid, rx_overrun, frame_err;

    logic [1:0]  tx_state;
    logic [15:0] tx_div, tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;

    logic [1:0]  rx_state;
    logic [15:0] rx_div, rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_s1, rx_s2, rx_s3;

    logic unused_bits;
    assign unused_bits = ^{addr_i[31:8], data_i[31:16]};

    logic [7:0] a;
    assign a = addr_i[7:0];

    logic wr_ctrl, wr_status, wr_baud, wr_txdata;
    assign wr_ctrl   = we_i && (a == 8'h00);
    assign wr_status = we_i && (a == 8'h04);
    assign wr_baud   = we_i && (a == 8'h08);
    assign wr_txdata = we_i && (a == 8'h0C);

    logic tx_busy, tx_bit_end, tx_start;
    assign tx_busy    = (tx_state != ST_IDLE);
    assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
    // A write landing on the edge that ends the stop bit chains straight
    // into the next frame without an idle gap.
    assign tx_start   = wr_txdata && ctrl[0] &&
                        (!tx_busy || (tx_state == ST_STOP && tx_bit_end));

    logic rx_bit_end, rx_half_end, rx_stop_sample;
    logic set_valid, set_overrun, set_ferr;
    assign rx_bit_end     = (rx_cnt == rx_div - 16'd1);
    assign rx_half_end    = (rx_cnt == (rx_div >> 1) - 16'd1);
    assign rx_stop_sample = ctrl[1] && (rx_state == ST_STOP) && rx_bit_end;
    assign set_valid      = rx_stop_sample && rx_s2 && !rx_valid;
    assign set_overrun    = rx_stop_sample && rx_s2 && rx_valid;
    assign set_ferr       = rx_stop_sample && !rx_s2;

    // Register file and status flags; a hardware set beats a bus clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl       <= 3'd0;
            baud       <= DEFAULT_W;
            txdata     <= 8'd0;
            rxdata     <= 8'd0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            if (wr_ctrl)   ctrl   <= data_i[2:0];
            if (wr_baud)   baud   <= (data_i[15:0] < MIN_W) ? MIN_W : data_i[15:0];
            if (wr_txdata) txdata <= data_i[7:0];
            if (set_valid) rxdata <= rx_shift;

            if (set_valid)                     rx_valid <= 1'b1;
            else if (wr_status && !data_i[1])  rx_valid <= 1'b0;
            if (set_overrun)                   rx_overrun <= 1'b1;
            else if (wr_status && !data_i[2])  rx_overrun <= 1'b0;
            if (set_ferr)                      frame_err <= 1'b1;
            else if (wr_status && !data_i[3])  frame_err <= 1'b0;

            irq_o <= ctrl[2] & rx_valid;
        end
    end

    // Transmitter: divisor latched at frame start, LSB first, one stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_o     <= 1'b1;
            tx_div   <= DEFAULT_W;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
        end else if (tx_start) begin
            tx_state <= ST_START;
            tx_o     <= 1'b0;
            tx_div   <= baud;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= data_i[7:0];
        end else if (tx_state != ST_IDLE) begin
            if (!tx_bit_end) begin
                tx_cnt <= tx_cnt + 16'd1;
            end else begin
                tx_cnt <= 16'd0;
                case (tx_state)
                    ST_START: begin
                        tx_state <= ST_DATA;
                        tx_o     <= tx_shift[0];
                    end
                    ST_DATA: begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_shift <= tx_shift >> 1;
                        if (tx_bit == 3'd7) begin
                            tx_state <= ST_STOP;
                            tx_o     <= 1'b1;
                        end else begin
                            tx_o <= tx_shift[1];
                        end
                    end
                    default: tx_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Receiver: 2-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= ST_IDLE;
            rx_div   <= DEFAULT_W;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            if (!ctrl[1]) begin
                rx_state <= ST_IDLE;
                rx_cnt   <= 16'd0;
            end else begin
                case (rx_state)
                    ST_IDLE: begin
                        if (rx_s3 && !rx_s2) begin
                            rx_state <= ST_START;
                            rx_div   <= baud;
                            rx_cnt   <= 16'd0;
                        end
                    end
                    ST_START: begin
                        if (rx_half_end) begin
                            // Line back high at mid start bit: treat as a glitch.
                            rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
                            rx_cnt   <= 16'd0;
                            rx_bit   <= 3'd0;
                        end else begin
                            rx_cnt <= rx_cnt + 16'd1;
                        end
                    end
                    ST_DATA: begin
                        if (rx_bit_end) begin
                            rx_shift <= {rx_s2, rx_shift[7:1]};
                            rx_cnt   <= 16'd0;
                            rx_bit   <= rx_bit + 3'd1;
                            if (rx_bit == 3'd7) rx_state <= ST_STOP;
                        end else begin
                            rx_cnt <= rx_cnt + 16'd1;
                        end
                    end
                    default: begin
                        if (rx_bit_end) begin
                            rx_state <= ST_IDLE;
                            rx_cnt   <= 16'd0;
                        end else begin
                            rx_cnt <= rx_cnt + 16'd1;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        data_o = 32'd0;
        case (a)
            8'h00:   data_o = {29'd0, ctrl};
            8'h04:   data_o = {28'd0, frame_err, rx_overrun, rx_valid, tx_busy};
            8'h08:   data_o = {16'd0, baud};
            8'h0C:   data_o = {24'd0, txdata};
            8'h10:   data_o = {24'd0, rxdata};
            default: data_o = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_uart_slave.sv
// tb_uart_slave: register-vector table, TX frame monitor with expected-byte
// queue, RX frames driven on rx_i with expected-byte queue, and hand-written
// sequences for overrun, framing error, glitch, flag clear and reset.
module tb_uart_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_i, data_i;
    logic [31:0] data_o;
    logic        we_i, rx_i, tx_o, irq_o;

    int checks   = 0;
    int failures = 0;
    int tb_div   = 8;
    logic mon_en = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_exp_q[$];

    uart_slave dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .we_i(we_i), .rx_i(rx_i), .tx_o(tx_o), .irq_o(irq_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_i = a;
        data_i = d;
        we_i   = 1'b1;
        @(negedge clk);
        we_i   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr_i = a;
        we_i   = 1'b0;
        #1 d = data_o;
    endtask

    task automatic count_busy(output int n);
        addr_i = 32'h04;
        we_i   = 1'b0;
        n = 0;
        #1;
        while (data_o[0] && n < 1000) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx_i = 1'b0;
        repeat (tb_div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (tb_div) @(negedge clk);
        end
        rx_i = stop;
        repeat (tb_div) @(negedge clk);
        rx_i = 1'b1;
        repeat (2 * tb_div) @(negedge clk);
    endtask

    // ---------------- TX monitor / scoreboard ----------------
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge tx_o);
            if (!mon_en) continue;
            repeat (tb_div / 2) @(posedge clk);
            #1 check("tx_start_bit", {31'd0, tx_o}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (tb_div) @(posedge clk);
                #1 b[i] = tx_o;
            end
            repeat (tb_div) @(posedge clk);
            #1 check("tx_stop_bit", {31'd0, tx_o}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected_frame actual=0x%0h required=none", b);
            end else begin
                check("tx_frame_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- register vector table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[19];

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] v;
        int n, n2;

        vecs[0]  = '{32'h08, 32'h0, 1'b0, 32'd434};
        vecs[1]  = '{32'h04, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{32'h00, 32'h0, 1'b0, 32'h0};
        vecs[3]  = '{32'h0C, 32'h0, 1'b0, 32'h0};
        vecs[4]  = '{32'h10, 32'h0, 1'b0, 32'h0};
        vecs[5]  = '{32'h08, 32'h1, 1'b1, 32'h0};
        vecs[6]  = '{32'h08, 32'h0, 1'b0, 32'd4};
        vecs[7]  = '{32'h08, 32'h0001_0009, 1'b1, 32'h0};
        vecs[8]  = '{32'h3000_0008, 32'h0, 1'b0, 32'd9};
        vecs[9]  = '{32'h00, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[10] = '{32'h00, 32'h0, 1'b0, 32'h7};
        vecs[11] = '{32'h00, 32'h0, 1'b1, 32'h0};
        vecs[12] = '{32'h0C, 32'h5A, 1'b1, 32'h0};
        vecs[13] = '{32'h0C, 32'h0, 1'b0, 32'h5A};
        vecs[14] = '{32'h04, 32'h0, 1'b0, 32'h0};
        vecs[15] = '{32'h14, 32'hFFFF, 1'b1, 32'h0};
        vecs[16] = '{32'h14, 32'h0, 1'b0, 32'h0};
        vecs[17] = '{32'h08, 32'h3, 1'b1, 32'h0};
        vecs[18] = '{32'h08, 32'h0, 1'b0, 32'd4};

        rst = 1'b1; addr_i = 32'h0; data_i = 32'h0; we_i = 1'b0; rx_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_o", {31'd0, tx_o}, 32'd1);
        check("rst_irq_o", {31'd0, irq_o}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                bus_read(vecs[i].addr, v);
                check($sformatf("reg_vec%0d", i), v, vecs[i].exp);
            end
        end
        check("idle_tx_o", {31'd0, tx_o}, 32'd1);

        // Basic TX frame 0xA5 at 8 clocks per bit.
        bus_write(32'h08, 32'd8);
        bus_write(32'h00, 32'h1);
        mon_en = 1'b1;
        exp_q.push_back(8'hA5);
        bus_write(32'h0C, 32'hA5);
        count_busy(n);
        check("tx_busy_cycles", n, 32'd80);

        // TXDATA write while busy only updates the readback value.
        exp_q.push_back(8'hC3);
        bus_write(32'h0C, 32'hC3);
        repeat (20) @(negedge clk);
        bus_write(32'h0C, 32'h11);
        bus_read(32'h0C, v);
        check("txdata_readback_busy", v, 32'h11);
        count_busy(n);
        repeat (30) @(negedge clk);
        check("tx_queue_after_ignored", exp_q.size(), 32'd0);

        // Back-to-back: second write lands on the edge ending the stop bit.
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'hF0);
        bus_write(32'h0C, 32'h0F);
        addr_i = 32'h04;
        #1;
        n = 0;
        for (int k = 0; k < 79; k++) begin
            if (data_o[0]) n++;
            @(negedge clk);
            #1;
        end
        addr_i = 32'h0C; data_i = 32'hF0; we_i = 1'b1;
        @(negedge clk);
        we_i = 1'b0;
        count_busy(n2);
        check("b2b_first_busy", n, 32'd79);
        check("b2b_second_busy", n2, 32'd80);
        repeat (20) @(negedge clk);
        check("tx_queue_empty", exp_q.size(), 32'd0);

        // Basic RX with interrupt timing.
        bus_write(32'h00, 32'h7);
        addr_i = 32'h04;
        rx_exp_q.push_back(8'h3C);
        fork
            send_rx(8'h3C, 1'b1);
            begin
                int w;
                w = 0;
                #1;
                while (!data_o[1] && w < 400) begin
                    @(negedge clk);
                    #1;
                    w++;
                end
                check("rx_valid_seen", {31'd0, w < 400}, 32'd1);
                check("irq_lag_cycle", {31'd0, irq_o}, 32'd0);
                @(negedge clk);
                #1 check("irq_next_cycle", {31'd0, irq_o}, 32'd1);
            end
        join
        bus_read(32'h10, v);
        check("rxdata_first", v, {24'd0, rx_exp_q.pop_front()});
        bus_read(32'h04, v);
        check("status_rx_valid", v, 32'h2);

        // Overrun: byte dropped, RXDATA kept.
        send_rx(8'h55, 1'b1);
        bus_read(32'h10, v);
        check("rxdata_after_overrun", v, 32'h3C);
        bus_read(32'h04, v);
        check("status_overrun", v, 32'h6);
        bus_write(32'h04, 32'h0);
        bus_read(32'h04, v);
        check("status_cleared", v, 32'h0);

        // Framing error.
        send_rx(8'h81, 1'b0);
        bus_read(32'h04, v);
        check("status_frame_err", v, 32'h8);
        bus_read(32'h10, v);
        check("rxdata_after_ferr", v, 32'h3C);
        bus_write(32'h04, 32'h0);

        // Two-cycle low glitch is rejected.
        @(negedge clk);
        rx_i = 1'b0;
        repeat (2) @(negedge clk);
        rx_i = 1'b1;
        repeat (120) @(negedge clk);
        bus_read(32'h04, v);
        check("glitch_status", v, 32'h0);
        bus_read(32'h10, v);
        check("glitch_rxdata", v, 32'h3C);

        // Flag clear and interrupt drop.
        rx_exp_q.push_back(8'h96);
        send_rx(8'h96, 1'b1);
        bus_read(32'h10, v);
        check("rxdata_second", v, {24'd0, rx_exp_q.pop_front()});
        check("irq_high", {31'd0, irq_o}, 32'd1);
        bus_write(32'h04, 32'hE);
        bus_read(32'h04, v);
        check("status_write_ones", v, 32'h2);
        bus_write(32'h04, 32'h0);
        addr_i = 32'h04;
        #1;
        check("status_after_clear", data_o, 32'h0);
        check("irq_same_cycle", {31'd0, irq_o}, 32'd1);
        @(negedge clk);
        #1 check("irq_dropped", {31'd0, irq_o}, 32'd0);

        // Reset in the middle of a TX frame.
        mon_en = 1'b0;
        bus_write(32'h0C, 32'h00);
        repeat (20) @(negedge clk);
        check("tx_mid_frame_low", {31'd0, tx_o}, 32'd0);
        rst = 1'b1;
        #1 check("rst_mid_frame_tx_o", {31'd0, tx_o}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus_read(32'h04, v);
        check("rst_status", v, 32'h0);
        bus_read(32'h08, v);
        check("rst_baud", v, 32'd434);
        check("rst_irq_after", {31'd0, irq_o}, 32'd0);
        check("rx_queue_empty", rx_exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
